mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- Integer multiply/divide functional unit (RV32M) sitting directly downstream of a reservation station.
- Consumes the station's issue interface (valid/opcode/iaddr/insn/src_a/src_b/tag) and back-pressures it with a busy stall.
- Executes one operation at a time with a fixed 32-iteration shift-add / restoring-divide datapath.
- Broadcasts the result on one Common Data Bus (CDB) lane for one cycle.

Parameters:
DATA_WIDTH, 32, operand/result width (iteration count equals DATA_WIDTH)
ADDR_WIDTH, 32, instruction address width
TAG_WIDTH, 6, reorder-buffer destination tag width
OPCODE_WIDTH, 7, opcode field width

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
i_flush  in  1  pipeline flush; aborts any in-flight op
i_fu_valid  in  1  issue valid from reservation station
i_fu_opcode  in  OPCODE_WIDTH  opcode (carried, not decoded)
i_fu_iaddr  in  ADDR_WIDTH  instruction address
i_fu_insn  in  DATA_WIDTH  instruction word; funct3 = insn[14:12]
i_fu_src_a  in  DATA_WIDTH  rs1 value
i_fu_src_b  in  DATA_WIDTH  rs2 value
i_fu_tag  in  TAG_WIDTH  destination tag
o_fu_stall  out  1  unit busy; station must not issue
o_cdb_en  out  1  result broadcast valid (one-cycle pulse)
o_cdb_redirect  out  1  always 0
o_cdb_data  out  DATA_WIDTH  result
o_cdb_addr  out  ADDR_WIDTH  instruction address of result
o_cdb_tag  out  TAG_WIDTH  destination tag of result

Behaviour:
- Reset: n_rst is asynchronous, active-low; clock is clk. On reset, state=IDLE, o_fu_stall=0, o_cdb_en=0, o_cdb_redirect=0, o_cdb_data/addr/tag=0.
- FSM states: IDLE, EXEC, DONE.
  - o_fu_stall = (state != IDLE).
  - Accept = IDLE & i_fu_valid & ~i_flush.
- IDLE:
  - On accept, latch funct3, iaddr, tag, operands (sign handling below); clear counter; go to EXEC.
  - Otherwise stay in IDLE.
- EXEC runs exactly DATA_WIDTH cycles (counter 0..31, increments by 1). At counter==31 the final iteration completes and the FSM goes to DONE.
- DONE:
  - o_cdb_en = ~i_flush; data/addr/tag are valid.
  - Next state is IDLE.
  - No new accept occurs in DONE.
- Latency: accept edge T → o_cdb_en high during cycle T+33 → IDLE (stall low) at T+34. Throughput is 1 op per 34 cycles.
- Flush: i_flush in any state forces IDLE at the next edge. o_cdb_en is gated low in the same cycle. A flush coinciding with i_fu_valid is not accepted.
- funct3 decode:
  - 000 MUL: low word of product.
  - 001 MULH: high word, signed×signed.
  - 010 MULHSU: high word, signed×unsigned.
  - 011 MULHU: high word, unsigned×unsigned.
  - 100 DIV, 101 DIVU: quotient.
  - 110 REM, 111 REMU: remainder.
- Signed ops:
  - Operate on absolute values; the sign flag is latched at accept.
  - Product is negated if operand signs differ.
  - Quotient is negated if signs differ; remainder takes the dividend's sign.
- Multiply: 2·DATA_WIDTH-bit accumulator; each cycle, if multiplier LSB is set, add multiplicand<<counter; then shift the multiplier right.
- Divide:
  - Restoring, MSB first.
  - Partial remainder is DATA_WIDTH+1 bits.
  - Each cycle: shift in the next dividend bit, trial-subtract, set quotient bit if non-negative.
- Divide special cases (same 32-cycle latency, no fast path):
  - Divisor 0: quotient = all ones (0xFFFFFFFF); remainder = dividend.
  - Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- All CDB outputs are registered. Data/addr/tag hold their last value outside DONE, and consumers ignore them when o_cdb_en=0.

Test Plan:
- Reset mid-EXEC (counter≈10) → outputs zero immediately; after release, stall=0, no CDB pulse.
- MUL 7×6 (funct3 000) accepted at T → o_cdb_en only at T+33, data=42, tag/addr echoed; stall high T+1..T+33, low T+34.
- MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000. MULHU same operands → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/0 → 0xFFFFFFFF; REMU 100/0 → 100; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM of the same → 0.
- i_flush at EXEC counter 15 → IDLE next cycle, no CDB pulse. i_flush during DONE → o_cdb_en stays 0. i_flush with i_fu_valid in IDLE → not accepted.
- Back-to-back: i_fu_valid held high with two ops → second accepted only at T+34, results at T+33 and T+67; a valid asserted while stall is high is ignored.

Source files
------------

// File: rtl/mul_div_unit.sv
// ----------------------------------------------------------------------------
// mul_div_unit
// RV32M integer multiply/divide unit. Takes one operation at a time from the
// reservation station, runs a DATA_WIDTH-iteration shift-add multiply or
// restoring divide, and broadcasts the result on one CDB lane for one cycle.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mul_div_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int TAG_WIDTH    = 6,
  parameter int OPCODE_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    i_flush,
  input  logic                    i_fu_valid,
  input  logic [OPCODE_WIDTH-1:0] i_fu_opcode,
  input  logic [ADDR_WIDTH-1:0]   i_fu_iaddr,
  input  logic [DATA_WIDTH-1:0]   i_fu_insn,
  input  logic [DATA_WIDTH-1:0]   i_fu_src_a,
  input  logic [DATA_WIDTH-1:0]   i_fu_src_b,
  input  logic [TAG_WIDTH-1:0]    i_fu_tag,
  output logic                    o_fu_stall,
  output logic                    o_cdb_en,
  output logic                    o_cdb_redirect,
  output logic [DATA_WIDTH-1:0]   o_cdb_data,
  output logic [ADDR_WIDTH-1:0]   o_cdb_addr,
  output logic [TAG_WIDTH-1:0]    o_cdb_tag
);

  localparam int                CNT_W  = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_n;

  // Latched operation context
  logic [2:0]              r_f3;
  logic                    r_neg_q;     // product / quotient negation
  logic                    r_neg_r;     // remainder follows dividend sign
  logic                    r_b_zero;    // divide by zero: quotient stays all ones
  logic [CNT_W-1:0]        r_cnt;
  logic [ADDR_WIDTH-1:0]   r_iaddr;
  logic [TAG_WIDTH-1:0]    r_tag;

  // Iteration registers.
  // r_x: multiplicand (mul) or dividend-in / quotient-out shift register (div)
  // r_y: multiplier shifted right (mul) or fixed divisor (div)
  logic [DATA_WIDTH-1:0]   r_x;
  logic [DATA_WIDTH-1:0]   r_y;
  logic [2*DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0]   r_rem;

  logic [DATA_WIDTH-1:0]   r_cdb_data;
  logic [ADDR_WIDTH-1:0]   r_cdb_addr;
  logic [TAG_WIDTH-1:0]    r_cdb_tag;

  // Issue-side decode
  logic [2:0]            w_f3;
  logic                  w_a_signed;
  logic                  w_b_signed;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [DATA_WIDTH-1:0] w_a_abs;
  logic [DATA_WIDTH-1:0] w_b_abs;
  logic                  w_accept;
  logic                  w_is_div;
  logic                  w_last;

  assign w_f3       = i_fu_insn[14:12];
  // MUL treats both operands as signed: the low word is the same either way.
  assign w_a_signed = w_f3[2] ? ~w_f3[0] : (w_f3 != 3'b011);
  assign w_b_signed = w_f3[2] ? ~w_f3[0] : (w_f3[1] == 1'b0);
  assign w_a_neg    = w_a_signed & i_fu_src_a[DATA_WIDTH-1];
  assign w_b_neg    = w_b_signed & i_fu_src_b[DATA_WIDTH-1];
  assign w_a_abs    = w_a_neg ? -i_fu_src_a : i_fu_src_a;
  assign w_b_abs    = w_b_neg ? -i_fu_src_b : i_fu_src_b;
  assign w_accept   = (r_state == ST_IDLE) & i_fu_valid & ~i_flush;
  assign w_is_div   = r_f3[2];
  assign w_last     = (r_cnt == C_LAST);

  // Multiply step
  logic [2*DATA_WIDTH-1:0] w_addend;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [2*DATA_WIDTH-1:0] w_prod_s;

  assign w_addend = {{DATA_WIDTH{1'b0}}, r_x} << r_cnt;
  assign w_prod   = r_acc + (r_y[0] ? w_addend : '0);
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;

  // Restoring divide step; the trial remainder is one bit wider than the data
  logic [DATA_WIDTH:0]   w_shift;
  logic [DATA_WIDTH:0]   w_trial;
  logic                  w_ge;
  logic [DATA_WIDTH-1:0] w_rem_n;
  logic [DATA_WIDTH-1:0] w_quo_n;
  logic [DATA_WIDTH-1:0] w_quo_s;
  logic [DATA_WIDTH-1:0] w_rem_s;

  assign w_shift = {r_rem, r_x[DATA_WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_y};
  assign w_ge    = ~w_trial[DATA_WIDTH];
  assign w_rem_n = w_ge ? w_trial[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
  assign w_quo_n = {r_x[DATA_WIDTH-2:0], w_ge};
  assign w_quo_s = (r_neg_q & ~r_b_zero) ? -w_quo_n : w_quo_n;
  assign w_rem_s = r_neg_r ? -w_rem_n : w_rem_n;

  logic [DATA_WIDTH-1:0] w_result;

  // Select the architectural result from the final iteration
  always_comb begin
    w_result = '0;
    case (r_f3)
      3'b000:          w_result = w_prod_s[DATA_WIDTH-1:0];
      3'b001, 3'b010,
      3'b011:          w_result = w_prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
      3'b100, 3'b101:  w_result = w_quo_s;
      default:         w_result = w_rem_s;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_n;
  end

  // Next-state, stall and CDB-valid decode; flush always wins
  always_comb begin
    w_state_n  = r_state;
    o_fu_stall = (r_state != ST_IDLE);
    o_cdb_en   = (r_state == ST_DONE) & ~i_flush;
    if (i_flush) begin
      w_state_n = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (i_fu_valid) w_state_n = ST_EXEC;
        ST_EXEC: if (w_last)     w_state_n = ST_DONE;
        default:                 w_state_n = ST_IDLE;
      endcase
    end
  end

  // Operand capture on accept, one datapath iteration per EXEC cycle
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_f3     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_cnt    <= '0;
      r_iaddr  <= '0;
      r_tag    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
    end else if (w_accept) begin
      r_f3     <= w_f3;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_b_zero <= (i_fu_src_b == '0);
      r_cnt    <= '0;
      r_iaddr  <= i_fu_iaddr;
      r_tag    <= i_fu_tag;
      r_x      <= w_a_abs;
      r_y      <= w_b_abs;
      r_acc    <= '0;
      r_rem    <= '0;
    end else if (r_state == ST_EXEC) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_is_div) begin
        r_rem <= w_rem_n;
        r_x   <= w_quo_n;
      end else begin
        r_acc <= w_prod;
        r_y   <= r_y >> 1;
      end
    end
  end

  // CDB payload registers, loaded as the final iteration completes
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cdb_data <= '0;
      r_cdb_addr <= '0;
      r_cdb_tag  <= '0;
    end else if ((r_state == ST_EXEC) && w_last && !i_flush) begin
      r_cdb_data <= w_result;
      r_cdb_addr <= r_iaddr;
      r_cdb_tag  <= r_tag;
    end
  end

  assign o_cdb_redirect = 1'b0;
  assign o_cdb_data     = r_cdb_data;
  assign o_cdb_addr     = r_cdb_addr;
  assign o_cdb_tag      = r_cdb_tag;

  // Opcode and the non-funct3 instruction bits are carried but not decoded
  logic w_unused;
  assign w_unused = ^{i_fu_opcode, i_fu_insn[DATA_WIDTH-1:15], i_fu_insn[11:0]};

endmodule

`default_nettype wire
